data_memory_bytelane: RTL and testbench
=======================================

# data_memory_bytelane

Byte-addressed, byte-lane-enabled data memory for the single-cycle MIPS datapath, replacing the word-only data memory. Supports LB/LBU/LH/LHU/LW loads and SB/SH/SW stores with sign/zero extension done inside the block. Array contents are not cleared by the asynchronous reset; instead a sequential clear engine zeroes one word per cycle after reset or on request, with `BUSY` flagging the sweep. Sits between the ALU result/register-file read port and the write-back mux.

## Interface
- `DEPTH`, default 256: number of 32-bit words; power of two, 4..65536.
- `TEST_ADDR`, default 0: word index mirrored onto `Test_Value`.
- `CLK` input 1: single clock, rising edge.
- `RST` input 1: reset, asynchronous, active-low.
- `A` input 32: byte address; word index is `A[AW+1:2]`, where AW = log2(DEPTH).
- `WD` input 32: store data; the value is taken from the low bits for byte and half stores.
- `WE` input 1: store strobe, sampled on the rising edge.
- `SIZE` input 2: access size; 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `SIGNED` input 1: sign-extend byte and half loads when 1; zero-extend when 0.
- `CLR` input 1: synchronous request to re-run the clear sweep.
- `RD` output 32: load data, extended (combinational).
- `BUSY` output 1: clear sweep in progress.
- `OOR` output 1: `A[31:2]` ≥ DEPTH (combinational).
- `MISALIGN` output 1: misaligned access flag (see Configuration).
- `Test_Value` output 16: bits [15:0] of word `TEST_ADDR`.

## Operation
- Endianness is little-endian. The byte lane is `A[1:0]` and the half lane is `A[1]`.
- FSM has two states, `INIT` and `READY`. A clear pointer `ptr` of AW bits belongs to the sweep.
- Async reset asserted: state goes to `INIT`, `ptr` to 0. Array contents are left untouched.
- In `INIT`, each edge writes `RAM[ptr] <= 0` and increments `ptr`.
  - On the edge that clears word DEPTH-1, the state goes to `READY`.
- `CLR` high at an edge, in either state: state goes to `INIT` and `ptr` to 0. Any store on that edge is dropped.
- Store rules:
  - A store commits only when the state is `READY`, `WE`=1, `CLR`=0, `OOR`=0 and the access is not suppressed by the misalign check.
  - Only the addressed lanes are written. SB writes one byte (`WD[7:0]`), SH writes two (`WD[15:0]`), SW writes all four.
  - The other lanes of the word are preserved.
- Load: `RD` is the addressed lane, extended to 32 bits per `SIGNED`. A word load ignores `SIGNED`.
- Forced-zero conditions:
  - `RD` = 0 while `BUSY`=1 or `OOR`=1.
  - `Test_Value` = 0 while `BUSY`=1.

## Timing
- Reset values:
  - `BUSY`=1.
  - `RD`=0 and `Test_Value`=0, because they are masked by `BUSY`.
  - `OOR` and `MISALIGN` follow `A`/`SIZE` combinationally.
- After `RST` is released, `BUSY` stays high for exactly DEPTH rising edges. It falls after the DEPTH-th edge.
- Reset asserted mid-sweep restarts the sweep from word 0. `CLR` mid-sweep also restarts it.
- Store latency is one edge. `RD` for the same address shows the old data before the edge and the new data after it; there is no bypass.
- `RD`, `OOR`, `MISALIGN` and `Test_Value` are purely combinational from `A`, `SIZE`, `SIGNED` and array state.
- Read and write to the same address in the same cycle: the read returns the pre-edge data.
- A store with `WE`=1 while `BUSY`=1 is silently dropped. The datapath must stall on `BUSY`.

## Configuration
- Macro `DMEM_MISALIGN_CHK_EN`.
- Defined:
  - `MISALIGN`=1 when `SIZE`=01 with `A[0]`=1, or when `SIZE`=10/11 with `A[1:0]`≠0.
  - A misaligned store is dropped. A misaligned load returns `RD`=0.
- Not defined:
  - `MISALIGN` is tied 0.
  - Half accesses ignore `A[0]`; word accesses ignore `A[1:0]`.
  - The access is performed at the aligned-down address.

## Test plan
- Reset release with DEPTH=256: `BUSY`=1 for 256 edges, then 0. Reading any address returns 0, and `Test_Value`=0.
- SW `0x8899AABB` at `A`=0x10, then LW 0x10 → `0x8899AABB`. Then SB `0x55` at 0x12 → LW gives `0x8855AABB`.
- With word 0x10 = `0x8855AABB`:
  - LB 0x12 signed → `0x00000055`. LB 0x13 signed → `0xFFFFFF88`.
  - LHU 0x12 → `0x00008855`. LH 0x12 signed → `0xFFFF8855`.
- SW to `A`=DEPTH*4 → `OOR`=1, no word changes, `RD`=0. `CLR` pulse after writing `0x1234` to word `TEST_ADDR`: `BUSY` is high for 256 edges, then `Test_Value`=0.
- With `DMEM_MISALIGN_CHK_EN`: SW at 0x21 → `MISALIGN`=1, word 0x20 unchanged. Without the macro: same store writes word 0x20, `MISALIGN`=0.
- `RST` pulsed low at sweep cycle 100: `ptr` restarts, and `BUSY` lasts a further 256 edges after release.

Source files
------------

// File: rtl/data_memory_bytelane.sv
// data_memory_bytelane: byte-addressed data memory with LB/LBU/LH/LHU/LW loads,
// SB/SH/SW stores and a one-word-per-cycle clear sweep after reset or CLR.
// Loads are combinational; stores commit on the rising edge; the datapath stalls on BUSY.
// Optional macro DMEM_MISALIGN_CHK_EN flags and suppresses misaligned accesses.
module data_memory_bytelane #(
  parameter int DEPTH     = 256,
  parameter int TEST_ADDR = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        WE,
  input  logic [1:0]  SIZE,
  input  logic        SIGNED,
  input  logic        CLR,
  output logic [31:0] RD,
  output logic        BUSY,
  output logic        OOR,
  output logic        MISALIGN,
  output logic [15:0] Test_Value
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] TIDX = AW'(TEST_ADDR);

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]    state;
  logic [AW-1:0] ptr;
  logic [31:0]   mem [0:DEPTH-1];

  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   rext;
  logic          sweep_we;
  logic          store_en;

  assign idx  = A[AW+1:2];
  assign BUSY = (state == ST_INIT);
  assign OOR  = ({2'b00, A[31:2]} >= 32'(DEPTH));

`ifdef DMEM_MISALIGN_CHK_EN
  // Half needs A[0]=0, word (and reserved size) needs A[1:0]=0.
  assign MISALIGN = ((SIZE == 2'b01) && A[0]) || (SIZE[1] && (A[1:0] != 2'b00));
`else
  // Accesses are silently aligned down by the lane selection below.
  assign MISALIGN = 1'b0;
`endif

  // The sweep only writes while reset is released and no restart is requested.
  assign sweep_we = (state == ST_INIT) && RST && !CLR;
  assign store_en = (state == ST_READY) && WE && !CLR && !OOR && !MISALIGN;

  // Byte enables and lane-replicated store data; little-endian lanes from A[1:0].
  always_comb begin
    be    = 4'b0000;
    wdata = WD;
    case (SIZE)
      2'b00: begin
        be    = 4'b0001 << A[1:0];
        wdata = {4{WD[7:0]}};
      end
      2'b01: begin
        be    = A[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WD[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = WD;
      end
    endcase
  end

  // Clear-sweep FSM: INIT walks ptr over every word, then READY until CLR/reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (CLR) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else if (state == ST_INIT) begin
      ptr <= ptr + AW'(1);
      if (ptr == LAST) begin
        state <= ST_READY;
      end
    end
  end

  // Array writes: sweep zeroing or a byte-lane store; contents survive reset.
  always_ff @(posedge CLK) begin
    if (sweep_we) begin
      mem[ptr] <= '0;
    end else if (store_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Lane extraction and sign/zero extension; word loads ignore SIGNED.
  always_comb begin
    rword = mem[idx];
    rbyte = rword[{A[1:0], 3'b000} +: 8];
    rhalf = A[1] ? rword[31:16] : rword[15:0];
    case (SIZE)
      2'b00:   rext = {{24{SIGNED & rbyte[7]}}, rbyte};
      2'b01:   rext = {{16{SIGNED & rhalf[15]}}, rhalf};
      default: rext = rword;
    endcase
  end

  assign RD         = (BUSY || OOR || MISALIGN) ? 32'h0 : rext;
  assign Test_Value = BUSY ? 16'h0 : mem[TIDX][15:0];

endmodule

// File: tb/tb_data_memory_bytelane.sv
// tb_data_memory_bytelane: randomized and directed stimulus against a byte-array
// reference model; expected outputs are queued per cycle and a monitor process
// pops and compares them on the falling edge.
module tb_data_memory_bytelane;

  localparam int DEPTH = 256;
  localparam int TADDR = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] WD = '0;
  logic        WE = 1'b0;
  logic [1:0]  SIZE = 2'b10;
  logic        SIGNED = 1'b0;
  logic        CLR = 1'b0;
  logic [31:0] RD;
  logic        BUSY;
  logic        OOR;
  logic        MISALIGN;
  logic [15:0] Test_Value;

  data_memory_bytelane #(.DEPTH(DEPTH), .TEST_ADDR(TADDR)) dut (
    .CLK(CLK), .RST(RST), .A(A), .WD(WD), .WE(WE), .SIZE(SIZE),
    .SIGNED(SIGNED), .CLR(CLR), .RD(RD), .BUSY(BUSY), .OOR(OOR),
    .MISALIGN(MISALIGN), .Test_Value(Test_Value)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          tag;
    logic [31:0] rd;
    logic        busy;
    logic        oor;
    logic        mis;
    logic [15:0] tv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  // Reference model: flat byte array plus the number of sweep edges still owed.
  logic [7:0] ref_mem [DEPTH*4];
  int         busy_left = DEPTH;

  function automatic logic m_oor(input logic [31:0] a);
    return (a >> 2) >= 32'(DEPTH);
  endfunction

  function automatic logic m_mis(input logic [31:0] a, input logic [1:0] sz);
`ifdef DMEM_MISALIGN_CHK_EN
    return ((sz == 2'd1) && (a % 2 != 0)) || ((sz >= 2'd2) && (a % 4 != 0));
`else
    return 1'b0;
`endif
  endfunction

  // First byte of the access within the flat array, aligned down per size.
  function automatic int m_base(input logic [31:0] a, input logic [1:0] sz);
    int w;
    int off;
    w = int'((a / 4) % 32'(DEPTH));
    if (sz == 2'd0)      off = int'(a % 4);
    else if (sz == 2'd1) off = int'(a % 4) / 2 * 2;
    else                 off = 0;
    return w * 4 + off;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int          b;
    logic [31:0] v;
    b = m_base(a, sz);
    if (sz == 2'd0) begin
      v = 32'(ref_mem[b]);
      if (sg && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = 32'(ref_mem[b]) + 32'(ref_mem[b+1]) * 32'd256;
      if (sg && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = 32'(ref_mem[b]) + 32'(ref_mem[b+1]) * 32'd256 +
          32'(ref_mem[b+2]) * 32'd65536 + 32'(ref_mem[b+3]) * 32'd16777216;
    end
    return v;
  endfunction

  task automatic zero_model();
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", nm, tag, act, exp);
    end
  endtask

  // One cycle: drive inputs, queue expected pre-edge outputs, advance the model.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                      input logic [1:0] sz, input logic sg, input logic clr,
                      input logic ovr, input logic [31:0] ovr_rd);
    exp_t        e;
    logic        bsy;
    logic        o;
    logic        m;
    int          b;
    int          n;
    A = a; WD = wd; WE = we; SIZE = sz; SIGNED = sg; CLR = clr;
    bsy = (busy_left > 0) || !RST;
    o   = m_oor(a);
    m   = m_mis(a, sz);
    e.tag  = step_no;
    e.busy = bsy;
    e.oor  = o;
    e.mis  = m;
    e.rd   = ovr ? ovr_rd : ((bsy || o || m) ? 32'h0 : m_load(a, sz, sg));
    e.tv   = bsy ? 16'h0 : {ref_mem[TADDR*4+1], ref_mem[TADDR*4]};
    sb.push_back(e);
    step_no++;
    @(posedge CLK);
    if (RST) begin
      if (clr) begin
        busy_left = DEPTH;
        zero_model();
      end else if (busy_left > 0) begin
        busy_left--;
      end else if (we && !o && !m) begin
        b = m_base(a, sz);
        n = (sz == 2'd0) ? 1 : ((sz == 2'd1) ? 2 : 4);
        for (int i = 0; i < n; i++) ref_mem[b+i] = wd[8*i +: 8];
      end
    end
    #1;
  endtask

  task automatic idle();
    step($urandom_range(0, DEPTH*4 - 1), $urandom, 1'b0, 2'($urandom_range(0, 3)),
         1'($urandom_range(0, 1)), 1'b0, 1'b0, 32'h0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    step(a, wd, 1'b1, sz, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic ld_exp(input logic [31:0] a, input logic [1:0] sz, input logic sg, input logic [31:0] exp);
    step(a, 32'h0, 1'b0, sz, sg, 1'b0, 1'b1, exp);
  endtask

  task automatic run_sweep();
    while (busy_left > 0) idle();
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("RD",         mon_e.tag, RD,                mon_e.rd);
      chk("BUSY",       mon_e.tag, 32'(BUSY),         32'(mon_e.busy));
      chk("OOR",        mon_e.tag, 32'(OOR),          32'(mon_e.oor));
      chk("MISALIGN",   mon_e.tag, 32'(MISALIGN),     32'(mon_e.mis));
      chk("Test_Value", mon_e.tag, 32'(Test_Value),   32'(mon_e.tv));
    end
  end

  initial begin
    zero_model();
    busy_left = DEPTH;
    @(posedge CLK);
    #1;
    // Reset held, then released: full sweep, everything reads zero.
    repeat (3) idle();
    RST = 1'b1;
    run_sweep();
    ld_exp(32'h10, 2'd2, 1'b0, 32'h0);
    ld_exp(32'h3FC, 2'd2, 1'b0, 32'h0);

    // Word store, byte store, then every load flavour on the same word.
    store(32'h10, 32'h8899_AABB, 2'd2);
    ld_exp(32'h10, 2'd2, 1'b0, 32'h8899_AABB);
    store(32'h12, 32'hFFFF_FF55, 2'd0);
    ld_exp(32'h10, 2'd2, 1'b0, 32'h8855_AABB);
    ld_exp(32'h12, 2'd0, 1'b1, 32'h0000_0055);
    ld_exp(32'h13, 2'd0, 1'b1, 32'hFFFF_FF88);
    ld_exp(32'h13, 2'd0, 1'b0, 32'h0000_0088);
    ld_exp(32'h12, 2'd1, 1'b0, 32'h0000_8855);
    ld_exp(32'h12, 2'd1, 1'b1, 32'hFFFF_8855);
    ld_exp(32'h10, 2'd1, 1'b1, 32'hFFFF_AABB);
    ld_exp(32'h10, 2'd2, 1'b1, 32'h8855_AABB);

    // Same-cycle read and write: pre-edge data, then new data.
    step(32'h10, 32'hCAFE_F00D, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h8855_AABB);
    ld_exp(32'h10, 2'd2, 1'b0, 32'hCAFE_F00D);

    // Out-of-range store: flagged, RD forced zero, no word changes.
    step(32'(DEPTH*4), 32'hBAD0_BAD0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h0);
    ld_exp(32'h0, 2'd2, 1'b0, 32'h0);
    ld_exp(32'h10, 2'd2, 1'b0, 32'hCAFE_F00D);

    // Misaligned word store.
    store(32'h20, 32'h1122_3344, 2'd2);
    store(32'h21, 32'hDEAD_BEEF, 2'd2);
`ifdef DMEM_MISALIGN_CHK_EN
    ld_exp(32'h20, 2'd2, 1'b0, 32'h1122_3344);
`else
    ld_exp(32'h20, 2'd2, 1'b0, 32'hDEAD_BEEF);
`endif

    // Test_Value mirror, then a CLR-triggered sweep wipes it.
    store(32'(TADDR*4), 32'h0000_1234, 2'd2);
    ld_exp(32'(TADDR*4), 2'd1, 1'b0, 32'h0000_1234);
    step(32'h0, 32'h0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0);
    run_sweep();
    ld_exp(32'(TADDR*4), 2'd2, 1'b0, 32'h0);
    ld_exp(32'h10, 2'd2, 1'b0, 32'h0);

    // Reset pulsed 100 edges into a sweep restarts it from word 0.
    step(32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0);
    repeat (100) idle();
    RST = 1'b0;
    busy_left = DEPTH;
    zero_model();
    repeat (2) idle();
    RST = 1'b1;
    run_sweep();
    ld_exp(32'h40, 2'd2, 1'b0, 32'h0);

    // Randomized mix of loads, stores, occasional out-of-range and CLR.
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] a;
      a = (i % 9 == 0) ? 32'($urandom_range(DEPTH*4, DEPTH*4 + 64))
                       : 32'($urandom_range(0, 127));
      step(a, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 399) == 0), 1'b0, 32'h0);
    end

    repeat (3) @(posedge CLK);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
